// File: rtl/sum_uart_tx.sv
// UART transmitter (8N1) with a valid/ready byte input and a registered serial line.
// Optional even parity bit between data and stop when SUM_UART_TX_PARITY_EN is defined.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

`ifdef SUM_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic parity_r;
  logic parity_nxt;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t               state_r;
  state_t               state_nxt;
  logic [BW-1:0]        baud_r;
  logic [BW-1:0]        baud_nxt;
  logic [IW-1:0]        bit_r;
  logic [IW-1:0]        bit_nxt;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 serial_r;
  logic                 serial_nxt;
  logic                 done_r;
  logic                 done_nxt;
  logic                 baud_end_s;
  logic                 accept_s;

  assign tx_ready   = (state_r == S_IDLE) & ena & rst_n;
  assign accept_s   = tx_valid & tx_ready;
  assign baud_end_s = (baud_r == BAUD_LAST);
  assign tx_serial  = serial_r;
  assign tx_done    = done_r;
  assign tx_busy    = (state_r != S_IDLE);

  // Next-state and next-output logic; every register holds unless its state acts on it.
  always_comb begin
    state_nxt  = state_r;
    baud_nxt   = baud_r;
    bit_nxt    = bit_r;
    shift_nxt  = shift_r;
    serial_nxt = serial_r;
    done_nxt   = 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
    parity_nxt = parity_r;
`endif
    case (state_r)
      S_IDLE: begin
        serial_nxt = 1'b1;
        baud_nxt   = {BW{1'b0}};
        bit_nxt    = {IW{1'b0}};
        if (accept_s) begin
          state_nxt  = S_START;
          shift_nxt  = tx_data;
          serial_nxt = 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
          parity_nxt = even_parity(tx_data);
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_nxt  = S_DATA;
          baud_nxt   = {BW{1'b0}};
          bit_nxt    = {IW{1'b0}};
          serial_nxt = shift_r[0];
        end else begin
          baud_nxt = baud_r + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_nxt = {BW{1'b0}};
          if (bit_r == BIT_LAST) begin
`ifdef SUM_UART_TX_PARITY_EN
            state_nxt  = S_PARITY;
            serial_nxt = parity_r;
`else
            state_nxt  = S_STOP;
            serial_nxt = 1'b1;
`endif
          end else begin
            // Output is registered, so the next bit is taken one position ahead.
            bit_nxt    = bit_r + IW'(1);
            shift_nxt  = {1'b0, shift_r[DATA_BITS-1:1]};
            serial_nxt = shift_r[1];
          end
        end else begin
          baud_nxt = baud_r + BW'(1);
        end
      end
`ifdef SUM_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end_s) begin
          state_nxt  = S_STOP;
          baud_nxt   = {BW{1'b0}};
          serial_nxt = 1'b1;
        end else begin
          baud_nxt = baud_r + BW'(1);
        end
      end
`endif
      S_STOP: begin
        // Raised one edge early so the pulse lands in the final stop-bit cycle.
        done_nxt = (baud_r == BAUD_PRE);
        if (baud_end_s) begin
          state_nxt  = S_IDLE;
          baud_nxt   = {BW{1'b0}};
          serial_nxt = 1'b1;
        end else begin
          baud_nxt = baud_r + BW'(1);
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        baud_nxt   = {BW{1'b0}};
        bit_nxt    = {IW{1'b0}};
        serial_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      baud_r   <= {BW{1'b0}};
      bit_r    <= {IW{1'b0}};
      shift_r  <= {DATA_BITS{1'b0}};
      serial_r <= 1'b1;
      done_r   <= 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else if (ena) begin
      state_r  <= state_nxt;
      baud_r   <= baud_nxt;
      bit_r    <= bit_nxt;
      shift_r  <= shift_nxt;
      serial_r <= serial_nxt;
      done_r   <= done_nxt;
`ifdef SUM_UART_TX_PARITY_EN
      parity_r <= parity_nxt;
`endif
    end else begin
      state_r  <= state_r;
      baud_r   <= baud_r;
      bit_r    <= bit_r;
      shift_r  <= shift_r;
      serial_r <= serial_r;
      done_r   <= done_r;
`ifdef SUM_UART_TX_PARITY_EN
      parity_r <= parity_r;
`endif
    end
  end

endmodule
